slc3_stim_seq: RTL
==================

# slc3_stim_seq

Synthesizable, parametrised stimulus sequencer that drives the SLC-3 processor's active-low reset, Run and Continue controls with a programmable pulse pattern. It replaces hand-timed bench stimulus for these controls and can also drive the same controls on the board for automated bring-up. Sequence: processor reset, then one Run pulse, then N Continue pulses. An optional mode gates each Continue pulse on the processor reporting a pause.

## Interface
Parameters:
- RST_CYC, 2: cycles CpuReset_n is held low (≥1)
- RUN_DLY, 3: idle cycles between reset release and the Run pulse (≥1)
- CONT_DLY, 5: minimum idle cycles before each Continue pulse (≥1)
- PULSE_CYC, 1: width in cycles of each Run and Continue pulse (≥1)
- N_CONT, 2: number of Continue pulses (0 = Run only)
- CNT_W, 8: width of the internal delay counter; every delay parameter must be < 2^CNT_W

Ports:
- Clk  in  1  system clock; all logic is on the rising edge
- Reset  in  1  reset, synchronous and active-low
- Start  in  1  begin a sequence; sampled in IDLE or DONE only
- Abort  in  1  cancel the sequence; returns to IDLE
- Pause  in  1  processor-paused indication; used only under SLC3_SEQ_PAUSE_WAIT_EN
- CpuReset_n  out  1  reset to the processor, active-low
- Run_n  out  1  Run control, active-low
- Continue_n  out  1  Continue control, active-low
- Busy  out  1  high in every state except IDLE and DONE
- Done  out  1  high while in DONE
- ContCount  out  $clog2(N_CONT+1) (min 1)  number of Continue pulses completed

## Operation
- States: IDLE, RST, RUN_WAIT, RUN_PULSE, CONT_WAIT, CONT_PULSE, DONE.
- Every output is registered and driven from the state register and counter.
- While Reset=0, all outputs take their reset values: CpuReset_n=1, Run_n=1, Continue_n=1, Busy=0, Done=0, ContCount=0. The state goes to IDLE.
- IDLE/DONE with Start=1 and Abort=0 → RST. The counter loads, ContCount clears and Done clears.
- RST: CpuReset_n=0 for RST_CYC cycles, then → RUN_WAIT.
- RUN_WAIT: all controls inactive for RUN_DLY cycles, then → RUN_PULSE.
- RUN_PULSE: Run_n=0 for PULSE_CYC cycles.
  - If N_CONT=0 → DONE.
  - Otherwise → CONT_WAIT.
- CONT_WAIT: all controls inactive for CONT_DLY cycles, then → CONT_PULSE. The Pause gating under the macro is described in Configuration.
- CONT_PULSE: Continue_n=0 for PULSE_CYC cycles. ContCount increments on the final pulse cycle.
  - If the new count equals N_CONT → DONE.
  - Otherwise → CONT_WAIT.
- DONE: Done=1 and ContCount holds until the next Start or Abort.
- Abort=1 in any state: next state is IDLE, all controls go inactive on the next edge, and Done=0. ContCount holds its value.
- Abort and Start asserted together: Abort wins.
- Start while Busy: ignored.
- Reset in mid-sequence: takes effect on the next edge regardless of state. Any pulse in progress is truncated.

## Timing
- Start is sampled at edge 0. CpuReset_n is low in cycles 1..RST_CYC.
- At most one of CpuReset_n, Run_n and Continue_n is low in any cycle.
- Consecutive control pulses are never adjacent: there is at least one all-inactive cycle between any two.
- Default-parameter sequence:
  - CpuReset_n low in cycles 1–2.
  - Idle in cycles 3–5.
  - Run_n low in cycle 6.
  - Idle in cycles 7–11.
  - Continue_n low in cycle 12; ContCount=1 from cycle 13.
  - Idle in cycles 13–17.
  - Continue_n low in cycle 18; ContCount=2 from cycle 19.
  - Done=1 and Busy=0 from cycle 19.
- Total latency from Start to Done = RST_CYC + RUN_DLY + PULSE_CYC + N_CONT·(CONT_DLY + PULSE_CYC) + 1.
- The delay counter counts down and saturates at 0. No wrap-around is permitted.

## Configuration
- Macro: SLC3_SEQ_PAUSE_WAIT_EN.
- Defined: CONT_WAIT exits only when the CONT_DLY count has expired and Pause=1 is sampled on the same edge. CONT_PULSE starts on the following cycle. With Pause held low, the block waits indefinitely, with Busy=1 and all controls inactive. Abort or Reset releases it.
- Undefined: Pause is ignored and CONT_WAIT lasts exactly CONT_DLY cycles.

## Test plan
- Default parameters, Start pulse at cycle 0 → the cycle-exact waveform in Timing, Done=1 at cycle 19, ContCount=2.
- N_CONT=0, RST_CYC=1, RUN_DLY=1, PULSE_CYC=3 → CpuReset_n low cycle 1, Run_n low cycles 3–5, Done at cycle 6, Continue_n never low.
- Abort asserted at cycle 7 with default parameters → IDLE, all controls high from cycle 8, Done=0, ContCount=0. A new Start then replays the full sequence from cycle 1.
- Reset=0 during a Run pulse at cycle 6 → all outputs at reset values after the edge. Start and Abort are ignored while Reset=0.
- With the macro, Pause=0 until cycle 20 → first Continue_n pulse at cycle 21, not 12. Busy stays 1 throughout.
- Start while Busy at cycle 4, and Start+Abort together in IDLE → no restart, no change of state.

Source files
------------

// File: rtl/slc3_stim_seq.sv
// slc3_stim_seq: stimulus sequencer for the SLC-3 CpuReset_n / Run_n / Continue_n controls
// Sequence: processor reset, one Run pulse, then N_CONT Continue pulses.
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-low reset
//   Start      in   begin a sequence (honoured in IDLE or DONE only)
//   Abort      in   cancel the sequence and return to IDLE (wins over Start)
//   Pause      in   processor-paused flag, gates Continue pulses when SLC3_SEQ_PAUSE_WAIT_EN is defined
//   CpuReset_n out  processor reset, active-low
//   Run_n      out  Run control, active-low
//   Continue_n out  Continue control, active-low
//   Busy       out  high outside IDLE and DONE
//   Done       out  high while in DONE
//   ContCount  out  number of Continue pulses completed
// Optional feature macro: SLC3_SEQ_PAUSE_WAIT_EN
module slc3_stim_seq #(
   parameter int RST_CYC   = 2,
   parameter int RUN_DLY   = 3,
   parameter int CONT_DLY  = 5,
   parameter int PULSE_CYC = 1,
   parameter int N_CONT    = 2,
   parameter int CNT_W     = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   input  logic Abort,
   input  logic Pause,
   output logic CpuReset_n,
   output logic Run_n,
   output logic Continue_n,
   output logic Busy,
   output logic Done,
   output logic [((N_CONT == 0) ? 1 : $clog2(N_CONT + 1))-1:0] ContCount
);
   localparam int CW = (N_CONT == 0) ? 1 : $clog2(N_CONT + 1);
   // each phase loads its length minus one so the phase ends on the cycle the counter reads zero
   localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] RUN_LD   = CNT_W'(RUN_DLY - 1);
   localparam logic [CNT_W-1:0] CONT_LD  = CNT_W'(CONT_DLY - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CW-1:0]    LAST     = CW'(N_CONT - 1);

   typedef enum logic [2:0] {IDLE, RST, RUN_WAIT, RUN_PULSE, CONT_WAIT, CONT_PULSE, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
   logic [CW-1:0]    cont_cnt_q, cont_cnt_d;
   logic             cpu_rst_n_q, cpu_rst_n_d;
   logic             run_n_q, run_n_d;
   logic             cont_n_q, cont_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cnt_zero;
   logic             go;

`ifdef SLC3_SEQ_PAUSE_WAIT_EN
   assign go = Pause;
`else
   logic unused_pause;
   assign go           = 1'b1;
   assign unused_pause = Pause;
`endif

   assign cnt_zero = (cnt_q == '0);
   // saturating decrement: the counter parks at zero while CONT_WAIT waits on Pause
   assign cnt_dec  = cnt_zero ? '0 : cnt_q - CNT_W'(1);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cont_cnt_q  <= '0;
         cpu_rst_n_q <= 1'b1;
         run_n_q     <= 1'b1;
         cont_n_q    <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cont_cnt_q  <= cont_cnt_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         run_n_q     <= run_n_d;
         cont_n_q    <= cont_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_dec;
      cont_cnt_d = cont_cnt_q;
      if (Abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: if (Start) begin
               state_d    = RST;
               cnt_d      = RST_LD;
               cont_cnt_d = '0;
            end
            RST: if (cnt_zero) begin
               state_d = RUN_WAIT;
               cnt_d   = RUN_LD;
            end
            RUN_WAIT: if (cnt_zero) begin
               state_d = RUN_PULSE;
               cnt_d   = PULSE_LD;
            end
            RUN_PULSE: if (cnt_zero) begin
               state_d = (N_CONT == 0) ? DONE : CONT_WAIT;
               cnt_d   = CONT_LD;
            end
            CONT_WAIT: if (cnt_zero && go) begin
               state_d = CONT_PULSE;
               cnt_d   = PULSE_LD;
            end
            CONT_PULSE: if (cnt_zero) begin
               cont_cnt_d = cont_cnt_q + CW'(1);
               state_d    = (cont_cnt_q == LAST) ? DONE : CONT_WAIT;
               cnt_d      = CONT_LD;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // outputs are decoded from the next state so the registered copies line up with state_q
   always_comb begin
      cpu_rst_n_d = (state_d != RST);
      run_n_d     = (state_d != RUN_PULSE);
      cont_n_d    = (state_d != CONT_PULSE);
      busy_d      = !(state_d == IDLE || state_d == DONE);
      done_d      = (state_d == DONE);
   end

   assign CpuReset_n = cpu_rst_n_q;
   assign Run_n      = run_n_q;
   assign Continue_n = cont_n_q;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign ContCount  = cont_cnt_q;
endmodule
